// File: rtl/target_bbox_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : target_bbox_tracker_pkg
//  Description : Shared defaults, FSM state encoding and bounding-box type
//                for the lock-on target tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package target_bbox_tracker_pkg;

    localparam int IMG_W_DEF   = 320;
    localparam int IMG_H_DEF   = 240;
    localparam int MIN_PIX_DEF = 16;
    // Wide enough for any supported image size; callers narrow to X_W/Y_W.
    localparam int COORD_W     = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
    } bbox_t;

endpackage
`default_nettype wire

// File: rtl/target_bbox_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : target_bbox_tracker_if
//  Description : Pixel-stream input and per-frame result bundle of the tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface target_bbox_tracker_if
    import target_bbox_tracker_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
);
    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);
    localparam int N_W = $clog2(IMG_W * IMG_H + 1);

    logic           frame_start;
    logic [7:0]     gray_in;
    logic           gray_valid;
    logic [7:0]     threshold;
    logic [X_W-1:0] bbox_x_min;
    logic [X_W-1:0] bbox_x_max;
    logic [Y_W-1:0] bbox_y_min;
    logic [Y_W-1:0] bbox_y_max;
    logic [N_W-1:0] hit_count;
    logic           target_found;
    logic           bbox_valid;
    logic           frame_err;

    modport master (
        output frame_start, gray_in, gray_valid, threshold,
        input  bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
        input  hit_count, target_found, bbox_valid, frame_err
    );

    modport slave (
        input  frame_start, gray_in, gray_valid, threshold,
        output bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
        output hit_count, target_found, bbox_valid, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/target_bbox_tracker_pixel_coord_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_coord_counter
//  Description : Raster (x,y) position of the next accepted pixel in a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_coord_counter #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int X_W   = $clog2(IMG_W),
    parameter int Y_W   = $clog2(IMG_H)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            // A pixel arriving with the clear is (0,0); the next one is (1,0).
            x <= advance ? X_W'(1) : '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_W'(IMG_W - 1)) begin
                x <= '0;
                y <= (y == Y_W'(IMG_H - 1)) ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

    assign last = (x == X_W'(IMG_W - 1)) && (y == Y_W'(IMG_H - 1));

endmodule
`default_nettype wire

// File: rtl/target_bbox_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : target_bbox_tracker
//  Description : Thresholds a grayscale stream and publishes a per-frame
//                bounding box and hit count of the bright target.
//  Revision    : 1.0 - initial release
// ============================================================================
module target_bbox_tracker
    import target_bbox_tracker_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int MIN_PIX = MIN_PIX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    target_bbox_tracker_if.slave  bus
);

    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);
    localparam int N_W = $clog2(IMG_W * IMG_H + 1);

    localparam bbox_t c_acc_init = '{
        x_min: COORD_W'(IMG_W - 1),
        x_max: '0,
        y_min: COORD_W'(IMG_H - 1),
        y_max: '0
    };

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_thr;
    bbox_t          r_acc;
    bbox_t          w_acc_nxt;
    logic [N_W-1:0] r_cnt;
    logic [N_W-1:0] w_cnt_nxt;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic           w_coord_last;
    logic           w_take;
    logic           w_hit;
    logic           w_last;
    logic           w_found;
    logic [7:0]     w_thr_eff;
    logic [X_W-1:0] w_px;
    logic [Y_W-1:0] w_py;

    logic [X_W-1:0] r_x_min;
    logic [X_W-1:0] r_x_max;
    logic [Y_W-1:0] r_y_min;
    logic [Y_W-1:0] r_y_max;
    logic [N_W-1:0] r_hit_count;
    logic           r_found;
    logic           r_frame_err;
    logic           w_bbox_valid;

    // frame_start always wins: a coincident pixel belongs to the new frame.
    assign w_take    = bus.gray_valid && (bus.frame_start || (r_state == ACCUM));
    assign w_thr_eff = bus.frame_start ? bus.threshold : r_thr;
    assign w_hit     = w_take && (bus.gray_in >= w_thr_eff);
    assign w_px      = bus.frame_start ? '0 : w_x;
    assign w_py      = bus.frame_start ? '0 : w_y;
    assign w_last    = w_take && !bus.frame_start && w_coord_last;
    assign w_found   = (w_cnt_nxt >= N_W'(MIN_PIX));

    pixel_coord_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_coord (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.frame_start),
        .advance (w_take),
        .x       (w_x),
        .y       (w_y),
        .last    (w_coord_last)
    );

    always_comb begin
        w_acc_nxt = bus.frame_start ? c_acc_init : r_acc;
        w_cnt_nxt = bus.frame_start ? '0 : r_cnt;
        if (w_hit) begin
            if (COORD_W'(w_px) < w_acc_nxt.x_min) w_acc_nxt.x_min = COORD_W'(w_px);
            if (COORD_W'(w_px) > w_acc_nxt.x_max) w_acc_nxt.x_max = COORD_W'(w_px);
            if (COORD_W'(w_py) < w_acc_nxt.y_min) w_acc_nxt.y_min = COORD_W'(w_py);
            if (COORD_W'(w_py) > w_acc_nxt.y_max) w_acc_nxt.y_max = COORD_W'(w_py);
            w_cnt_nxt = w_cnt_nxt + N_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_thr <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            if (bus.frame_start) r_thr <= bus.threshold;
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Results are loaded with the last pixel so they are already stable
    // during the PUBLISH cycle that raises bbox_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_min     <= '0;
            r_x_max     <= '0;
            r_y_min     <= '0;
            r_y_max     <= '0;
            r_hit_count <= '0;
            r_found     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= bus.frame_start && (r_state == ACCUM);
            if (w_last) begin
                r_hit_count <= w_cnt_nxt;
                r_found     <= w_found;
                r_x_min     <= w_found ? w_acc_nxt.x_min[X_W-1:0] : '0;
                r_x_max     <= w_found ? w_acc_nxt.x_max[X_W-1:0] : '0;
                r_y_min     <= w_found ? w_acc_nxt.y_min[Y_W-1:0] : '0;
                r_y_max     <= w_found ? w_acc_nxt.y_max[Y_W-1:0] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.frame_start) w_state_nxt = ACCUM;
            ACCUM:   if (bus.frame_start) w_state_nxt = ACCUM;
                     else if (w_last)     w_state_nxt = PUBLISH;
            PUBLISH: w_state_nxt = bus.frame_start ? ACCUM : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_bbox_valid = (r_state == PUBLISH);
    end

    assign bus.bbox_x_min   = r_x_min;
    assign bus.bbox_x_max   = r_x_max;
    assign bus.bbox_y_min   = r_y_min;
    assign bus.bbox_y_max   = r_y_max;
    assign bus.hit_count    = r_hit_count;
    assign bus.target_found = r_found;
    assign bus.bbox_valid   = w_bbox_valid;
    assign bus.frame_err    = r_frame_err;

endmodule
`default_nettype wire
